sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter AW, default 12, word-address width of the shared SP_SRAM port.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter LOCK_MAX, default 16, maximum consecutive cycles M1 may hold a locked grant.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RSTn  input  1  asynchronous, active-low reset.
REQ-006 M0_REQ / M1_REQ  input  1  access request (M0 = CPU data port, M1 = serial loader).
REQ-007 M0_WEN / M1_WEN  input  1  active-low write enable (1 = read).
REQ-008 M0_ADDR / M1_ADDR  input  AW  word address.
REQ-009 M0_BE / M1_BE  input  DW/8  byte enables.
REQ-010 M0_WDATA / M1_WDATA  input  DW  write data.
REQ-011 M1_LOCK  input  1  M1 requests exclusive back-to-back ownership.
REQ-012 M0_GNT / M1_GNT  output  1  request accepted this cycle (combinational).
REQ-013 M0_RVALID / M1_RVALID  output  1  read data valid, one cycle after granted read.
REQ-014 M0_RDATA / M1_RDATA  output  DW  read data.
REQ-015 MEM_CSN  output  1  active-low SRAM chip select.
REQ-016 MEM_ADDR, MEM_WEN, MEM_BE, MEM_DI  output  AW/1/DW/8/DW  muxed SRAM command.
REQ-017 MEM_DOUT  input  DW  SRAM read data, valid one cycle after CSN low with WEN=1.

Function
REQ-018 At most one of M0_GNT/M1_GNT SHALL be high in any cycle; GNT implies corresponding REQ.
REQ-019 MEM_CSN SHALL be low exactly when a grant is issued; MEM_ADDR/WEN/BE/DI SHALL equal the winner's inputs; when idle, MEM_WEN=1, MEM_BE=0, others 0.
REQ-020 Arbiter states: RR (round-robin) and LOCK1 (M1 owns port).
REQ-021 RR, single requester: that requester granted.
REQ-022 RR, both requesting: grant the port not granted most recently (register LAST updated on every grant).
REQ-023 RR -> LOCK1 on edge where M1 granted with M1_LOCK=1; lock counter loads 1.
REQ-024 LOCK1: M1_GNT follows M1_REQ, M0_GNT=0, counter increments per M1 grant.
REQ-025 LOCK1 -> RR when M1_LOCK=0, or counter reaches LOCK_MAX; on LOCK_MAX exit, next cycle M0 SHALL win if requesting, regardless of M1_LOCK.
REQ-026 Idle cycles in LOCK1 (M1_REQ=0, M1_LOCK=1) SHALL not increment counter and SHALL not release the lock.
REQ-027 Granted read: RVALID of that port high exactly the following cycle, RDATA = MEM_DOUT captured into a per-port register; other port's RVALID low.
REQ-028 RDATA SHALL hold last returned value until next read return for that port.
REQ-029 Writes SHALL produce no RVALID.
REQ-030 Back-to-back grants SHALL sustain one access per cycle; read return and new grant may coincide.
REQ-031 Request inputs SHALL be held by requester until GNT; arbiter keeps no request queue.

Reset
REQ-032 RSTn low SHALL asynchronously force state RR, LAST=M1 (M0 wins first tie), counter 0, all RVALID 0, all RDATA 0.
REQ-033 While RSTn low, MEM_CSN=1 and both GNT=0 regardless of REQ.
REQ-034 Reset during pending read SHALL discard the return; no RVALID after release.

Verification
REQ-035 Both REQ read, addr 0x004/0x008 held 4 cycles after reset -> grants M0,M1,M0,M1; RVALID alternates one cycle later with matching RDATA.
REQ-036 M0 write addr 0x010 data 0xDEADBEEF BE=1111, then M1 read 0x010 -> M1_RVALID with M1_RDATA=0xDEADBEEF; no RVALID for write.
REQ-037 M1_LOCK=1, both REQ continuous, LOCK_MAX=16 -> 16 consecutive M1 grants, then M0 granted next cycle.
REQ-038 LOCK1 with M1_REQ gapped 3 idle cycles -> M0 never granted, counter unchanged during gaps.
REQ-039 RSTn asserted cycle after M0 read grant -> M0_RVALID stays 0, MEM_CSN=1, first tie post-reset granted to M0.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-master arbiter for a single-port SRAM: round-robin between the CPU data port (M0)
// and the serial loader (M1), with a bounded exclusive lock mode for M1.
module sram_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic            CLK,
    input  logic            RSTn,

    input  logic            M0_REQ,
    input  logic            M0_WEN,
    input  logic [AW-1:0]   M0_ADDR,
    input  logic [DW/8-1:0] M0_BE,
    input  logic [DW-1:0]   M0_WDATA,
    output logic            M0_GNT,
    output logic            M0_RVALID,
    output logic [DW-1:0]   M0_RDATA,

    input  logic            M1_REQ,
    input  logic            M1_WEN,
    input  logic [AW-1:0]   M1_ADDR,
    input  logic [DW/8-1:0] M1_BE,
    input  logic [DW-1:0]   M1_WDATA,
    input  logic            M1_LOCK,
    output logic            M1_GNT,
    output logic            M1_RVALID,
    output logic [DW-1:0]   M1_RDATA,

    output logic            MEM_CSN,
    output logic [AW-1:0]   MEM_ADDR,
    output logic            MEM_WEN,
    output logic [DW/8-1:0] MEM_BE,
    output logic [DW-1:0]   MEM_DI,
    input  logic [DW-1:0]   MEM_DOUT
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic {RR, LOCK1} state_t;

    state_t          state, state_next;
    logic            last_m1, last_m1_next;
    logic [CW-1:0]   lock_cnt, lock_cnt_next;
    logic            gnt0, gnt1;
    logic            pend0, pend1;
    logic [DW-1:0]   rdata0_q, rdata1_q;

    // LAST resets to M1 so that M0 wins the first tie after reset.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= RR;
            last_m1  <= 1'b1;
            lock_cnt <= '0;
        end else begin
            state    <= state_next;
            last_m1  <= last_m1_next;
            lock_cnt <= lock_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        last_m1_next  = last_m1;
        if (gnt0)
            last_m1_next = 1'b0;
        else if (gnt1)
            last_m1_next = 1'b1;
        case (state)
            RR: begin
                if (gnt1 && M1_LOCK && (LOCK_MAX > 1)) begin
                    state_next    = LOCK1;
                    lock_cnt_next = CW'(1);
                end
            end
            LOCK1: begin
                if (gnt1)
                    lock_cnt_next = lock_cnt + 1'b1;
                // Leaving at LOCK_MAX returns to RR with LAST=M1, so a waiting M0 wins next.
                if (!M1_LOCK || (gnt1 && (lock_cnt_next == CW'(LOCK_MAX)))) begin
                    state_next    = RR;
                    lock_cnt_next = '0;
                end
            end
            default: state_next = RR;
        endcase
    end

    // Grants are gated by RSTn so nothing reaches the SRAM while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (RSTn) begin
            case (state)
                RR: begin
                    if (M0_REQ && M1_REQ) begin
                        gnt0 = last_m1;
                        gnt1 = !last_m1;
                    end else begin
                        gnt0 = M0_REQ;
                        gnt1 = M1_REQ;
                    end
                end
                LOCK1: gnt1 = M1_REQ;
                default: ;
            endcase
        end
    end

    always_comb begin
        MEM_CSN  = !(gnt0 || gnt1);
        MEM_ADDR = '0;
        MEM_WEN  = 1'b1;
        MEM_BE   = '0;
        MEM_DI   = '0;
        if (gnt0) begin
            MEM_ADDR = M0_ADDR;
            MEM_WEN  = M0_WEN;
            MEM_BE   = M0_BE;
            MEM_DI   = M0_WDATA;
        end else if (gnt1) begin
            MEM_ADDR = M1_ADDR;
            MEM_WEN  = M1_WEN;
            MEM_BE   = M1_BE;
            MEM_DI   = M1_WDATA;
        end
    end

    assign M0_GNT = gnt0;
    assign M1_GNT = gnt1;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pend0    <= 1'b0;
            pend1    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            pend0 <= gnt0 && M0_WEN;
            pend1 <= gnt1 && M1_WEN;
            if (pend0)
                rdata0_q <= MEM_DOUT;
            if (pend1)
                rdata1_q <= MEM_DOUT;
        end
    end

    // During the return cycle the SRAM output is passed straight through; afterwards it is held.
    assign M0_RVALID = pend0;
    assign M1_RVALID = pend1;
    assign M0_RDATA  = pend0 ? MEM_DOUT : rdata0_q;
    assign M1_RDATA  = pend1 ? MEM_DOUT : rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM stub, cycle-level reference model checked every
// negedge, and directed scenarios with literal expectations.
module tb_sram_arbiter;

    localparam int AW       = 12;
    localparam int DW       = 32;
    localparam int LOCK_MAX = 16;
    localparam int DEPTH    = 1 << AW;

    logic            clock;
    logic            rstN;
    logic            m0Req, m0Wen, m1Req, m1Wen, m1Lock;
    logic [AW-1:0]   m0Addr, m1Addr;
    logic [DW/8-1:0] m0Be, m1Be;
    logic [DW-1:0]   m0Wdata, m1Wdata;
    logic            m0Gnt, m1Gnt, m0Rvalid, m1Rvalid;
    logic [DW-1:0]   m0Rdata, m1Rdata;
    logic            memCsn, memWen;
    logic [AW-1:0]   memAddr;
    logic [DW/8-1:0] memBe;
    logic [DW-1:0]   memDi, memDout;

    int checks = 0;
    int errors = 0;
    int hist[$];

    logic [DW-1:0] sram  [DEPTH];
    logic [DW-1:0] mMem  [DEPTH];

    sram_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .CLK(clock), .RSTn(rstN),
        .M0_REQ(m0Req), .M0_WEN(m0Wen), .M0_ADDR(m0Addr), .M0_BE(m0Be), .M0_WDATA(m0Wdata),
        .M0_GNT(m0Gnt), .M0_RVALID(m0Rvalid), .M0_RDATA(m0Rdata),
        .M1_REQ(m1Req), .M1_WEN(m1Wen), .M1_ADDR(m1Addr), .M1_BE(m1Be), .M1_WDATA(m1Wdata),
        .M1_LOCK(m1Lock), .M1_GNT(m1Gnt), .M1_RVALID(m1Rvalid), .M1_RDATA(m1Rdata),
        .MEM_CSN(memCsn), .MEM_ADDR(memAddr), .MEM_WEN(memWen), .MEM_BE(memBe),
        .MEM_DI(memDi), .MEM_DOUT(memDout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] initWord(input int a);
        return 32'hC0DE_0000 | DW'(a);
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered-output SRAM stub with byte-enabled writes.
    always @(posedge clock) begin
        if (!memCsn) begin
            if (memWen)
                memDout <= sram[memAddr];
            else
                for (int b = 0; b < DW/8; b++)
                    if (memBe[b]) sram[memAddr][8*b +: 8] <= memDi[8*b +: 8];
        end
    end

    // Reference model: who may win, what the SRAM sees, and what each port reads back.
    bit            mLocked, eG0, eG1;
    int            mLast, mCnt;
    bit            mPend0, mPend1;
    logic [DW-1:0] mPdata0, mPdata1, mHold0, mHold1;

    always @(negedge clock) begin
        if (!rstN) begin
            mLocked = 0; mLast = 1; mCnt = 0;
            mPend0 = 0; mPend1 = 0; mHold0 = '0; mHold1 = '0;
            checkOutput("rst_m0_gnt", DW'(m0Gnt), 0);
            checkOutput("rst_m1_gnt", DW'(m1Gnt), 0);
            checkOutput("rst_csn", DW'(memCsn), 1);
            checkOutput("rst_m0_rvalid", DW'(m0Rvalid), 0);
            checkOutput("rst_m1_rvalid", DW'(m1Rvalid), 0);
            checkOutput("rst_m0_rdata", m0Rdata, 0);
            checkOutput("rst_m1_rdata", m1Rdata, 0);
        end else begin
            if (mPend0) mHold0 = mPdata0;
            if (mPend1) mHold1 = mPdata1;
            checkOutput("m0_rvalid", DW'(m0Rvalid), DW'(mPend0));
            checkOutput("m1_rvalid", DW'(m1Rvalid), DW'(mPend1));
            checkOutput("m0_rdata", m0Rdata, mHold0);
            checkOutput("m1_rdata", m1Rdata, mHold1);

            if (mLocked) begin
                eG0 = 0; eG1 = m1Req;
            end else if (m0Req && m1Req) begin
                eG0 = (mLast == 1); eG1 = !eG0;
            end else begin
                eG0 = m0Req; eG1 = m1Req;
            end
            checkOutput("m0_gnt", DW'(m0Gnt), DW'(eG0));
            checkOutput("m1_gnt", DW'(m1Gnt), DW'(eG1));
            checkOutput("mem_csn", DW'(memCsn), DW'(!(eG0 || eG1)));
            checkOutput("mem_addr", DW'(memAddr), eG0 ? DW'(m0Addr) : eG1 ? DW'(m1Addr) : 0);
            checkOutput("mem_wen", DW'(memWen), eG0 ? DW'(m0Wen) : eG1 ? DW'(m1Wen) : 1);
            checkOutput("mem_be", DW'(memBe), eG0 ? DW'(m0Be) : eG1 ? DW'(m1Be) : 0);
            checkOutput("mem_di", memDi, eG0 ? m0Wdata : eG1 ? m1Wdata : 0);
            hist.push_back(m0Gnt ? 0 : (m1Gnt ? 1 : -1));

            mPend0 = eG0 && m0Wen;
            mPend1 = eG1 && m1Wen;
            if (mPend0) mPdata0 = mMem[m0Addr];
            if (mPend1) mPdata1 = mMem[m1Addr];
            for (int b = 0; b < DW/8; b++) begin
                if (eG0 && !m0Wen && m0Be[b]) mMem[m0Addr][8*b +: 8] = m0Wdata[8*b +: 8];
                if (eG1 && !m1Wen && m1Be[b]) mMem[m1Addr][8*b +: 8] = m1Wdata[8*b +: 8];
            end
            if (eG0) mLast = 0;
            if (eG1) mLast = 1;
            if (!mLocked) begin
                if (eG1 && m1Lock) begin
                    mCnt = 1;
                    mLocked = (LOCK_MAX > 1);
                end
            end else begin
                if (eG1) mCnt++;
                if (!m1Lock || mCnt == LOCK_MAX) begin
                    mLocked = 0; mCnt = 0;
                end
            end
        end
    end

    task automatic applyStimulus(
        input logic m0r, input logic m0w, input logic [AW-1:0] m0a, input logic [3:0] m0b,
        input logic [DW-1:0] m0d,
        input logic m1r, input logic m1w, input logic [AW-1:0] m1a, input logic [3:0] m1b,
        input logic [DW-1:0] m1d, input logic m1l);
        m0Req = m0r; m0Wen = m0w; m0Addr = m0a; m0Be = m0b; m0Wdata = m0d;
        m1Req = m1r; m1Wen = m1w; m1Addr = m1a; m1Be = m1b; m1Wdata = m1d; m1Lock = m1l;
        @(posedge clock);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        int m1Count;
        bool_found: begin end
        for (int a = 0; a < DEPTH; a++) begin
            sram[a] = initWord(a);
            mMem[a] = initWord(a);
        end
        memDout = '0;
        rstN = 1'b0;
        m0Req = 0; m0Wen = 1; m0Addr = 0; m0Be = 0; m0Wdata = 0;
        m1Req = 0; m1Wen = 1; m1Addr = 0; m1Be = 0; m1Wdata = 0; m1Lock = 0;

        // Reset held with both masters requesting.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 12'h004, 4'hF, 0, 1, 1, 12'h008, 4'hF, 0, 0);
            checkOutput("reset_m0_gnt_lit", DW'(m0Gnt), 0);
            checkOutput("reset_csn_lit", DW'(memCsn), 1);
        end

        $display("[TB] alternating reads");
        hist.delete();
        rstN = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 1, 12'h004, 4'hF, 0, 1, 1, 12'h008, 4'hF, 0, 0);
        checkOutput("rr_seq0", DW'(hist[0]), 0);
        checkOutput("rr_seq1", DW'(hist[1]), 1);
        checkOutput("rr_seq2", DW'(hist[2]), 0);
        checkOutput("rr_seq3", DW'(hist[3]), 1);
        checkOutput("rr_m1_rvalid_lit", DW'(m1Rvalid), 1);
        checkOutput("rr_m1_rdata_lit", m1Rdata, 32'hC0DE_0008);
        checkOutput("rr_m0_rvalid_off_lit", DW'(m0Rvalid), 0);
        idleCycle();
        checkOutput("rr_m0_rdata_hold_lit", m0Rdata, 32'hC0DE_0004);

        $display("[TB] write then read");
        applyStimulus(1, 0, 12'h010, 4'hF, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 0);
        checkOutput("wr_no_rvalid_lit", DW'(m0Rvalid), 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 12'h010, 4'hF, 0, 0);
        checkOutput("wr_m1_rvalid_lit", DW'(m1Rvalid), 1);
        checkOutput("wr_m1_rdata_lit", m1Rdata, 32'hDEAD_BEEF);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 12'h010, 4'b0011, 32'h1122_3344, 0);
        applyStimulus(1, 1, 12'h010, 4'hF, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("be_m0_rdata_lit", m0Rdata, 32'hDEAD_3344);
        idleCycle();

        $display("[TB] lock held to its limit");
        hist.delete();
        for (int i = 0; i < LOCK_MAX + 1; i++)
            applyStimulus(1, 1, 12'h020, 4'hF, 0, 1, 1, 12'h030, 4'hF, 0, 1);
        m1Count = 0;
        for (int i = 0; i < LOCK_MAX; i++)
            if (hist[i] == 1) m1Count++;
        checkOutput("lockmax_m1_grants", DW'(m1Count), 16);
        checkOutput("lockmax_then_m0", DW'(hist[LOCK_MAX]), 0);
        idleCycle();

        $display("[TB] lock with idle gaps");
        hist.delete();
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 12'h030, 4'hF, 0, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 1, 12'h040, 4'hF, 0, 0, 1, 12'h030, 4'hF, 0, 1);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1, 1, 12'h040, 4'hF, 0, 1, 1, 12'h031, 4'hF, 0, 1);
            if (hist[$] == 0) break;
        end
        checkOutput("gap_idle0", DW'(hist[1]), DW'(-1));
        checkOutput("gap_idle1", DW'(hist[2]), DW'(-1));
        checkOutput("gap_idle2", DW'(hist[3]), DW'(-1));
        m1Count = 0;
        foreach (hist[i])
            if (hist[i] == 1) m1Count++;
        checkOutput("gap_m1_grants", DW'(m1Count), 16);
        checkOutput("gap_m0_finally", DW'(hist[$]), 0);
        idleCycle();

        $display("[TB] lock released by M1_LOCK");
        hist.delete();
        applyStimulus(1, 1, 12'h050, 4'hF, 0, 1, 1, 12'h060, 4'hF, 0, 1);
        applyStimulus(1, 1, 12'h050, 4'hF, 0, 1, 1, 12'h060, 4'hF, 0, 0);
        applyStimulus(1, 1, 12'h050, 4'hF, 0, 1, 1, 12'h060, 4'hF, 0, 0);
        checkOutput("unlock_seq0", DW'(hist[0]), 1);
        checkOutput("unlock_seq1", DW'(hist[1]), 1);
        checkOutput("unlock_seq2", DW'(hist[2]), 0);
        idleCycle();

        $display("[TB] reset during pending read");
        applyStimulus(1, 1, 12'h070, 4'hF, 0, 0, 1, 0, 0, 0, 0);
        rstN = 1'b0;
        m1Req = 1'b1;
        #1;
        checkOutput("rstpend_m0_rvalid_lit", DW'(m0Rvalid), 0);
        checkOutput("rstpend_csn_lit", DW'(memCsn), 1);
        checkOutput("rstpend_m0_gnt_lit", DW'(m0Gnt), 0);
        applyStimulus(1, 1, 12'h070, 4'hF, 0, 1, 1, 12'h071, 4'hF, 0, 0);
        applyStimulus(1, 1, 12'h070, 4'hF, 0, 1, 1, 12'h071, 4'hF, 0, 0);
        hist.delete();
        rstN = 1'b1;
        applyStimulus(1, 1, 12'h070, 4'hF, 0, 1, 1, 12'h071, 4'hF, 0, 0);
        checkOutput("postrst_first_tie_m0", DW'(hist[0]), 0);
        idleCycle();
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
